dmem_arbiter: RTL

//  Shares the byte-addressed data memory between two requesters: CPU load/store (Cpu*) and debug/loader (Dbg*).

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports (CPU, debug/loader) and the data-memory
//   port of dmem_arbiter. Signal prefixes are from the arbiter's point of view:
//   i_* flow into the arbiter, o_* flow out of it.
//   slave  : arbiter side
//   master : requester + memory side (testbench / SoC glue)
//   Per requester: req, we, addr, wdata in; ack, rdata, err out.
//   Memory: address, write_data, write, read out; read_data in. busy out.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 24
);
   logic              i_cpu_req;
   logic              i_cpu_we;
   logic [ADDR_W-1:0] i_cpu_addr;
   logic [DATA_W-1:0] i_cpu_wdata;
   logic              o_cpu_ack;
   logic [DATA_W-1:0] o_cpu_rdata;
   logic              o_cpu_err;

   logic              i_dbg_req;
   logic              i_dbg_we;
   logic [ADDR_W-1:0] i_dbg_addr;
   logic [DATA_W-1:0] i_dbg_wdata;
   logic              o_dbg_ack;
   logic [DATA_W-1:0] o_dbg_rdata;
   logic              o_dbg_err;

   logic [ADDR_W-1:0] o_mem_address;
   logic [DATA_W-1:0] o_mem_write_data;
   logic              o_mem_write;
   logic              o_mem_read;
   logic [DATA_W-1:0] i_mem_read_data;
   logic              o_busy;

   modport slave (
      input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
      output o_cpu_ack, o_cpu_rdata, o_cpu_err,
      input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      output o_dbg_ack, o_dbg_rdata, o_dbg_err,
      output o_mem_address, o_mem_write_data, o_mem_write, o_mem_read,
      input  i_mem_read_data,
      output o_busy
   );

   modport master (
      output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
      input  o_cpu_ack, o_cpu_rdata, o_cpu_err,
      output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      input  o_dbg_ack, o_dbg_rdata, o_dbg_err,
      input  o_mem_address, o_mem_write_data, o_mem_write, o_mem_read,
      output i_mem_read_data,
      input  o_busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter sharing a byte-addressed data memory between the CPU
//   load/store port and the debug/loader port. One 3-byte access at a time:
//   IDLE (grant + latch) -> ACCESS (memory strobe) -> DONE (ack pulse).
//   Ports:
//     i_clk  : clock, all logic on posedge
//     i_rst  : synchronous active-high reset
//     bus    : dmem_arbiter_if.slave (requesters, memory, busy)
module dmem_arbiter #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 24,
   parameter int DATA_W = 24
) (
   input  logic          i_clk,
   input  logic          i_rst,
   dmem_arbiter_if.slave bus
);
   localparam int NUM_PORTS = 2;           // index 0 = CPU, 1 = DBG
   localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(DEPTH - 3);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t                               r_state;
   logic                                 r_last;    // last granted port id
   logic                                 r_gnt;     // currently granted port id
   logic                                 r_we;
   logic                                 r_err;
   logic [ADDR_W-1:0]                    r_addr;    // doubles as memory Address
   logic [DATA_W-1:0]                    r_wdata;   // doubles as memory WriteData
   logic                                 r_busy;
   logic [NUM_PORTS-1:0]                 r_ack;
   logic [NUM_PORTS-1:0]                 r_err_q;
   logic [NUM_PORTS-1:0][DATA_W-1:0]     r_rdata_q;

   logic [NUM_PORTS-1:0]                 w_req;
   req_t [NUM_PORTS-1:0]                 w_port;
   logic                                 w_pick;
   req_t                                 w_sel;

   always_comb begin
      w_req     = {bus.i_dbg_req, bus.i_cpu_req};
      w_port[0] = '{we: bus.i_cpu_we, addr: bus.i_cpu_addr, wdata: bus.i_cpu_wdata};
      w_port[1] = '{we: bus.i_dbg_we, addr: bus.i_dbg_addr, wdata: bus.i_dbg_wdata};
      // On a tie the port that did not win last time goes next; otherwise
      // whichever single port is requesting.
      w_pick    = (&w_req) ? ~r_last : w_req[1];
      w_sel     = w_port[w_pick];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b1;     // DBG, so the CPU wins the first tie
         r_gnt     <= 1'b0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_ack     <= '0;
         r_err_q   <= '0;
         r_rdata_q <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_req) begin
                  r_gnt   <= w_pick;
                  r_we    <= w_sel.we;
                  r_addr  <= w_sel.addr;
                  r_wdata <= w_sel.wdata;
                  // Full-width compare: high address bits never alias back
                  // into the memory.
                  r_err   <= (w_sel.addr > LP_MAX_ADDR);
                  r_busy  <= 1'b1;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_ack[r_gnt]     <= 1'b1;
               r_err_q[r_gnt]   <= r_err;
               r_rdata_q[r_gnt] <= (~r_we & ~r_err) ? bus.i_mem_read_data : '0;
               r_state          <= S_DONE;
            end
            S_DONE: begin
               r_ack     <= '0;
               r_err_q   <= '0;
               r_rdata_q <= '0;
               r_last    <= r_gnt;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_cpu_ack        = r_ack[0];
   assign bus.o_cpu_err        = r_err_q[0];
   assign bus.o_cpu_rdata      = r_rdata_q[0];
   assign bus.o_dbg_ack        = r_ack[1];
   assign bus.o_dbg_err        = r_err_q[1];
   assign bus.o_dbg_rdata      = r_rdata_q[1];
   assign bus.o_mem_address    = r_addr;
   assign bus.o_mem_write_data = r_wdata;
   assign bus.o_busy           = r_busy;
   // Strobes decoded from the state register so they cover exactly ACCESS.
   assign bus.o_mem_write      = (r_state == S_ACCESS) &  r_we & ~r_err;
   assign bus.o_mem_read       = (r_state == S_ACCESS) & ~r_we & ~r_err;
endmodule
